// File: rtl/sp_ctrl_if.sv
// sp_ctrl_if: request/status and stack-memory bundle between the SP controller (slave)
// and its environment (master: requester, SP adder and stack memory).
interface sp_ctrl_if;
  logic        Push;
  logic        Pop;
  logic [15:0] PushData;
  logic [15:0] NewSP;
  logic [15:0] MemData;
  logic [15:0] SP;
  logic        IorD;
  logic [15:0] MemAddr;
  logic [15:0] MemWData;
  logic        MemWrite;
  logic        MemRead;
  logic [15:0] PopData;
  logic        Ready;
  logic        Done;
  logic        Err;

  modport master (
    output Push, Pop, PushData, NewSP, MemData,
    input  SP, IorD, MemAddr, MemWData, MemWrite, MemRead, PopData, Ready, Done, Err
  );

  modport slave (
    input  Push, Pop, PushData, NewSP, MemData,
    output SP, IorD, MemAddr, MemWData, MemWrite, MemRead, PopData, Ready, Done, Err
  );
endinterface

// File: rtl/sp_ctrl.sv
// sp_ctrl: sequences pre-decrement push / post-increment pop through an external SP adder.
// Define SP_BOUNDS_CHECK_EN to add a depth counter that rejects overflow/underflow with Err.
module sp_ctrl (
  input logic      CLK,
  input logic      Reset,
  sp_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_ADJ = 3'd1,
    PUSH_WR  = 3'd2,
    POP_RD   = 3'd3,
    POP_ADJ  = 3'd4
  } state_t;

  state_t      state;
  state_t      nextState;
  logic        errNxt;
  logic        pushBlocked;
  logic        popBlocked;
  logic [15:0] spReg;
  logic [15:0] popDataReg;
  logic [15:0] wDataReg;
  logic        memWriteReg;
  logic        memReadReg;
  logic        iorDReg;
  logic        readyReg;
  logic        doneReg;
  logic        errReg;

`ifdef SP_BOUNDS_CHECK_EN
  localparam logic [16:0] DepthMax = 17'h0F400;
  logic [16:0] depth;

  // Occupancy: completed pushes minus completed pops.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      depth <= 17'd0;
    end else if (state == PUSH_WR) begin
      depth <= depth + 17'd1;
    end else if (state == POP_ADJ) begin
      depth <= depth - 17'd1;
    end else begin
      depth <= depth;
    end
  end

  assign pushBlocked = (depth == DepthMax);
  assign popBlocked  = (depth == 17'd0);
`else
  assign pushBlocked = 1'b0;
  assign popBlocked  = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state; Push has priority and a blocked request only raises Err.
  always_comb begin
    nextState = state;
    errNxt    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Push) begin
          if (pushBlocked) begin
            errNxt = 1'b1;
          end else begin
            nextState = PUSH_ADJ;
          end
        end else if (bus.Pop) begin
          if (popBlocked) begin
            errNxt = 1'b1;
          end else begin
            nextState = POP_RD;
          end
        end else begin
          nextState = IDLE;
        end
      end
      PUSH_ADJ: nextState = PUSH_WR;
      PUSH_WR:  nextState = IDLE;
      POP_RD:   nextState = POP_ADJ;
      POP_ADJ:  nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      spReg       <= 16'h0000;
      popDataReg  <= 16'h0000;
      wDataReg    <= 16'h0000;
      memWriteReg <= 1'b0;
      memReadReg  <= 1'b0;
      iorDReg     <= 1'b1;
      readyReg    <= 1'b1;
      doneReg     <= 1'b0;
      errReg      <= 1'b0;
    end else begin
      memWriteReg <= (nextState == PUSH_WR);
      memReadReg  <= (nextState == POP_RD);
      iorDReg     <= (nextState != PUSH_ADJ);
      readyReg    <= (nextState == IDLE);
      doneReg     <= (state == PUSH_WR) || (state == POP_ADJ);
      errReg      <= errNxt;
      if ((state == PUSH_ADJ) || (state == POP_ADJ)) begin
        spReg <= bus.NewSP;
      end
      if (state == POP_ADJ) begin
        popDataReg <= bus.MemData;
      end
      if ((state == IDLE) && (nextState == PUSH_ADJ)) begin
        wDataReg <= bus.PushData;
      end
    end
  end

  assign bus.SP       = spReg;
  assign bus.MemAddr  = spReg;
  assign bus.MemWData = wDataReg;
  assign bus.MemWrite = memWriteReg;
  assign bus.MemRead  = memReadReg;
  assign bus.IorD     = iorDReg;
  assign bus.PopData  = popDataReg;
  assign bus.Ready    = readyReg;
  assign bus.Done     = doneReg;
  assign bus.Err      = errReg;

endmodule
